// File: rtl/hdlc_tx_arbiter.sv
// Round-robin frame scheduler for a shared HDLC transmit FIFO.
// Writes header + payload words into the current slot, then commits the slot.
module hdlc_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_len,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      word_ack,
    output logic [NREQ-1:0]      done,
    output logic                 len_err,
    output logic [15:0]          stall_cnt,
    input  logic                 stall_clr,
    input  logic                 fifo_full,
    output logic [2:0]           fifo_addr,
    output logic [15:0]          fifo_din,
    output logic                 fifo_wr,
    output logic                 fifo_commit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_COMMIT,
        S_SETTLE
    } state_t;

    localparam logic [3:0] LAST_INIT = 4'(NREQ - 1);

    state_t      state_reg, state_next;
    logic [3:0]  chan_reg, chan_next;
    logic [2:0]  len_reg, len_next;
    logic [2:0]  idx_reg, idx_next;
    logic [3:0]  last_reg, last_next;
    logic [15:0] stall_reg, stall_next;
    logic        len_err_reg, len_err_next;

    // Per-requester views padded to 16 entries so a 4-bit channel indexes them exactly.
    logic [15:0] req_ext;
    logic [2:0]  len_arr  [16];
    logic [15:0] data_arr [16];

    assign req_ext = 16'(req);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            if (gi < NREQ) begin : g_real
                assign len_arr[gi]  = req_len[3*gi +: 3];
                assign data_arr[gi] = req_data[16*gi +: 16];
            end else begin : g_absent
                assign len_arr[gi]  = 3'd0;
                assign data_arr[gi] = 16'd0;
            end
        end
    endgenerate

    // Round-robin search starting one past the last served channel.
    logic       pick_found;
    logic [3:0] pick_chan;
    logic [4:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_chan  = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 5'(last_reg) + 5'(k);
            if (cand >= 5'(NREQ)) begin
                cand = cand - 5'(NREQ);
            end
            if (!pick_found && req_ext[cand[3:0]]) begin
                pick_found = 1'b1;
                pick_chan  = cand[3:0];
            end
        end
    end

    logic [2:0]      len_sel;
    logic [NREQ-1:0] chan_onehot;

    assign len_sel     = len_arr[pick_chan];
    assign chan_onehot = {{(NREQ-1){1'b0}}, 1'b1} << chan_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            chan_reg    <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            last_reg    <= LAST_INIT;
            stall_reg   <= '0;
            len_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            chan_reg    <= chan_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            stall_reg   <= stall_next;
            len_err_reg <= len_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        chan_next    = chan_reg;
        len_next     = len_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        stall_next   = stall_reg;
        len_err_next = len_err_reg;

        grant        = '0;
        word_ack     = '0;
        done         = '0;
        fifo_wr      = 1'b0;
        fifo_commit  = 1'b0;
        fifo_addr    = '0;
        fifo_din     = '0;

        // Clear wins over a same-cycle stall.
        if (stall_clr) begin
            stall_next = '0;
        end else if (state_reg == S_IDLE && pick_found && fifo_full
                     && stall_reg != 16'hFFFF) begin
            stall_next = stall_reg + 16'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (pick_found && !fifo_full) begin
                    chan_next  = pick_chan;
                    state_next = S_HDR;
                    if (len_sel == 3'd7) begin
                        len_next     = 3'd6;
                        len_err_next = 1'b1;
                    end else begin
                        len_next = len_sel;
                    end
                end
            end
            S_HDR: begin
                grant      = chan_onehot;
                fifo_wr    = 1'b1;
                fifo_addr  = 3'd0;
                fifo_din   = {4'hA, chan_reg, 5'b0, len_reg};
                idx_next   = 3'd1;
                state_next = S_DATA;
            end
            S_DATA: begin
                grant     = chan_onehot;
                word_ack  = chan_onehot;
                fifo_wr   = 1'b1;
                fifo_addr = idx_reg;
                fifo_din  = data_arr[chan_reg];
                idx_next  = idx_reg + 3'd1;
                if (idx_reg == len_reg + 3'd1) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                grant       = chan_onehot;
                done        = chan_onehot;
                fifo_commit = 1'b1;
                last_next   = chan_reg;
                state_next  = S_SETTLE;
            end
            S_SETTLE: begin
                // Lets the FIFO's registered full flag catch up with the commit.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign stall_cnt = stall_reg;
    assign len_err   = len_err_reg;

endmodule

// File: tb/tb_hdlc_tx_arbiter.sv
// Directed bench for hdlc_tx_arbiter with a behavioural 8-slot frame FIFO
// and per-requester payload sources that advance on word_ack.
module tb_hdlc_tx_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [11:0] req_len;
    logic [63:0] req_data;
    logic [3:0]  grant, word_ack, done;
    logic        len_err;
    logic [15:0] stall_cnt;
    logic        stall_clr;
    logic        fifo_full;
    logic [2:0]  fifo_addr;
    logic [15:0] fifo_din;
    logic        fifo_wr, fifo_commit;

    always #5 clk = ~clk;

    hdlc_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_len     (req_len),
        .req_data    (req_data),
        .grant       (grant),
        .word_ack    (word_ack),
        .done        (done),
        .len_err     (len_err),
        .stall_cnt   (stall_cnt),
        .stall_clr   (stall_clr),
        .fifo_full   (fifo_full),
        .fifo_addr   (fifo_addr),
        .fifo_din    (fifo_din),
        .fifo_wr     (fifo_wr),
        .fifo_commit (fifo_commit)
    );

    // FIFO model: one slot kept empty, full flag registered from the pointers.
    logic [2:0]  wptr = 3'd0, rptr = 3'd0;
    logic        full_reg = 1'b0;
    logic        force_full = 1'b0;
    logic        auto_read = 1'b1;
    logic        rd_once = 1'b0;
    logic        rd;
    logic [15:0] mem [64];
    logic [15:0] hdr_q [$];
    int          wr_cnt = 0, commit_cnt = 0, ack_cnt = 0;

    assign fifo_full = full_reg | force_full;
    assign rd = (auto_read | rd_once) && (rptr != wptr);

    always @(posedge clk) begin
        if (fifo_commit) wptr <= wptr + 3'd1;
        if (rd) rptr <= rptr + 3'd1;
        full_reg <= (wptr + 3'd1 == rptr);
        if (fifo_wr) mem[{wptr, fifo_addr}] <= fifo_din;
        if (fifo_wr && fifo_addr == 3'd0) hdr_q.push_back(fifo_din);
        wr_cnt     <= wr_cnt + (fifo_wr ? 1 : 0);
        commit_cnt <= commit_cnt + (fifo_commit ? 1 : 0);
        ack_cnt    <= ack_cnt + $countones(word_ack);
    end

    function automatic logic [15:0] pay(input int i, input int k);
        return 16'(32'h1111 * (k + 1) + 32'h0100 * i);
    endfunction

    logic [2:0] wcnt [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_n || done[i]) wcnt[i] <= 3'd0;
            else if (word_ack[i]) wcnt[i] <= wcnt[i] + 3'd1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[16*i +: 16] = pay(i, int'(wcnt[i]));
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(|(grant & ~req & ~done)))
                else $error("protocol: req dropped while granted (grant=%b req=%b)", grant, req);
        end
    end

    int n_vec = 0, n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_done(input int ch, input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done[ch] !== 1'b1 && cycles < bound);
        if (done[ch] !== 1'b1) check($sformatf("done%0d_timeout", ch), 32'(done[ch]), 32'd1);
    endtask

    task automatic wait_any_done(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done === 4'b0 && cycles < bound);
        if (done === 4'b0) check("any_done_timeout", 32'(done), 32'd1);
    endtask

    // Requests one frame, drops req on done, returns in the following IDLE cycle.
    task automatic run_frame(input int ch, input logic [2:0] len, output int cycles);
        req_len[3*ch +: 3] = len;
        req[ch] = 1'b1;
        wait_done(ch, 60, cycles);
        req[ch] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int         cyc, w0, a0, c0, q0;
    logic [2:0] slot;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = '0; req_len = '0; stall_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",     32'(grant),       32'd0);
        check("rst_word_ack",  32'(word_ack),    32'd0);
        check("rst_done",      32'(done),        32'd0);
        check("rst_fifo_wr",   32'(fifo_wr),     32'd0);
        check("rst_commit",    32'(fifo_commit), 32'd0);
        check("rst_fifo_din",  32'(fifo_din),    32'd0);
        check("rst_fifo_addr", 32'(fifo_addr),   32'd0);
        check("rst_stall_cnt", 32'(stall_cnt),   32'd0);
        check("rst_len_err",   32'(len_err),     32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Round robin from reset: order 0,1,2,3,0, len 0 => 5-cycle frames.
        c0 = commit_cnt; q0 = hdr_q.size();
        req = 4'hF;
        wait_any_done(60, cyc);
        check("rr_first_lat", 32'(cyc), 32'd3);
        for (int f = 1; f < 5; f++) begin
            wait_any_done(60, cyc);
            check($sformatf("rr_interval%0d", f), 32'(cyc), 32'd5);
        end
        req = '0;
        repeat (2) @(negedge clk);
        check("rr_commits", 32'(commit_cnt - c0), 32'd5);
        check("rr_hdr_count", 32'(hdr_q.size() - q0), 32'd5);
        for (int f = 0; f < 5; f++) begin
            if (q0 + f < hdr_q.size())
                check($sformatf("rr_hdr%0d", f), 32'(hdr_q[q0 + f]), 32'(16'hA000 | (16'(f % 4) << 8)));
        end

        // Single requester 0, three payload words; done in the 6th cycle counting the IDLE decision.
        slot = wptr; w0 = wr_cnt; a0 = ack_cnt; c0 = commit_cnt;
        run_frame(0, 3'd2, cyc);
        check("t1_done_lat", 32'(cyc), 32'd5);
        check("t1_hdr",  32'(mem[{slot, 3'd0}]), 32'h0000A002);
        check("t1_w1",   32'(mem[{slot, 3'd1}]), 32'h00001111);
        check("t1_w2",   32'(mem[{slot, 3'd2}]), 32'h00002222);
        check("t1_w3",   32'(mem[{slot, 3'd3}]), 32'h00003333);
        check("t1_wr",   32'(wr_cnt - w0),       32'd4);
        check("t1_ack",  32'(ack_cnt - a0),      32'd3);
        check("t1_commit", 32'(commit_cnt - c0), 32'd1);

        // Forced full for 10 cycles on requester 2.
        stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
        check("stall_cleared", 32'(stall_cnt), 32'd0);
        w0 = wr_cnt; c0 = commit_cnt;
        force_full = 1'b1; req_len[8:6] = 3'd0; req[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_10",    32'(stall_cnt),   32'd10);
        check("stall_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("stall_grant", 32'(grant),       32'd0);
        stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
        check("stall_clr_prio", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        check("stall_resume", 32'(stall_cnt), 32'd1);
        force_full = 1'b0;
        wait_done(2, 60, cyc);
        req[2] = 1'b0;
        check("stall_frame_lat", 32'(cyc), 32'd3);
        repeat (2) @(negedge clk);
        check("stall_commit", 32'(commit_cnt - c0), 32'd1);
        stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
        check("stall_final_clr", 32'(stall_cnt), 32'd0);

        // req_len 7 clamps to 6: header A106, seven payload words, sticky len_err.
        check("len_err_pre", 32'(len_err), 32'd0);
        slot = wptr; a0 = ack_cnt;
        run_frame(1, 3'd7, cyc);
        check("l7_lat", 32'(cyc), 32'd9);
        check("l7_hdr", 32'(mem[{slot, 3'd0}]), 32'h0000A106);
        for (int k = 1; k <= 7; k++)
            check($sformatf("l7_w%0d", k), 32'(mem[{slot, 3'(k)}]), 32'(pay(1, k - 1)));
        check("l7_ack", 32'(ack_cnt - a0), 32'd7);
        check("l7_len_err", 32'(len_err), 32'd1);
        run_frame(0, 3'd0, cyc);
        check("l7_len_err_sticky", 32'(len_err), 32'd1);

        // Fill the FIFO with the reader idle: 7 commits => full, 8th waits for a read.
        repeat (3) @(negedge clk);
        auto_read = 1'b0;
        for (int n = 0; n < 7; n++) run_frame(3, 3'd0, cyc);
        check("fill_full", 32'(fifo_full), 32'd1);
        w0 = wr_cnt; c0 = commit_cnt;
        stall_clr = 1'b1; @(negedge clk); stall_clr = 1'b0;
        req[3] = 1'b1;
        repeat (5) @(negedge clk);
        check("fill_wait_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("fill_wait_stall", 32'(stall_cnt),   32'd5);
        check("fill_wait_grant", 32'(grant),       32'd0);
        rd_once = 1'b1; @(negedge clk); rd_once = 1'b0;
        wait_done(3, 60, cyc);
        req[3] = 1'b0;
        repeat (2) @(negedge clk);
        check("fill_8th_wr",     32'(wr_cnt - w0),     32'd2);
        check("fill_8th_commit", 32'(commit_cnt - c0), 32'd1);
        auto_read = 1'b1;
        repeat (10) @(negedge clk);

        // Reset during DATA at idx 3; no commit, then a full frame from HDR.
        c0 = commit_cnt;
        req_len[8:6] = 3'd4; req[2] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(fifo_wr === 1'b1 && fifo_addr === 3'd3) && cyc < 60);
        check("mid_reach_idx3", 32'(fifo_addr), 32'd3);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_grant",    32'(grant),       32'd0);
        check("mid_fifo_wr",  32'(fifo_wr),     32'd0);
        check("mid_commit",   32'(fifo_commit), 32'd0);
        check("mid_word_ack", 32'(word_ack),    32'd0);
        check("mid_done",     32'(done),        32'd0);
        check("mid_len_err",  32'(len_err),     32'd0);
        check("mid_stall",    32'(stall_cnt),   32'd0);
        @(negedge clk);
        check("mid_no_commit", 32'(commit_cnt - c0), 32'd0);
        q0 = hdr_q.size(); w0 = wr_cnt; slot = wptr;
        reset_n = 1'b1;
        wait_done(2, 60, cyc);
        req[2] = 1'b0;
        check("mid_relat", 32'(cyc), 32'd7);
        repeat (2) @(negedge clk);
        check("mid_hdr_count", 32'(hdr_q.size() - q0), 32'd1);
        if (q0 < hdr_q.size()) check("mid_hdr", 32'(hdr_q[q0]), 32'h0000A204);
        check("mid_wr", 32'(wr_cnt - w0), 32'd6);
        check("mid_commit_after", 32'(commit_cnt - c0), 32'd1);
        for (int k = 1; k <= 5; k++)
            check($sformatf("mid_w%0d", k), 32'(mem[{slot, 3'(k)}]), 32'(pay(2, k - 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
